// File: rtl/mem_init_watchdog.sv
// DDR bring-up supervisor: holds the memory reset controller in reset until the PLL is
// locked, waits for calibration, and retries a bounded number of times before giving up.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// ST_WAIT_CLK | PLL not locked; memory held in reset
// ST_RESET    | reset pulse of RESET_CYCLES in progress
// ST_WAIT_OK  | reset released; waiting for a stable mem_ok or the timeout
// ST_READY    | memory up; any loss of mem_ok is a failure
// ST_FAILED   | retries exhausted; sticky until reset or force_retry
module mem_init_watchdog #(
    parameter int RESET_CYCLES   = 64,
    parameter int TIMEOUT_CYCLES = 16777216,
    parameter int STABLE_CYCLES  = 256,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             clock_ok,
    input  logic                             mem_ok,
    input  logic                             force_retry,
    output logic                             mem_reset_req,
    output logic                             mem_ready,
    output logic                             mem_failed,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam int STB_W = $clog2(STABLE_CYCLES + 1);
    localparam int RTY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [STB_W-1:0] STABLE_LAST  = STB_W'(STABLE_CYCLES - 1);
    localparam logic [STB_W-1:0] STABLE_MAX   = STB_W'(STABLE_CYCLES);
    localparam logic [RTY_W-1:0] RETRY_MAX    = RTY_W'(MAX_RETRIES);

    localparam logic [2:0] ST_WAIT_CLK = 3'd0;
    localparam logic [2:0] ST_RESET    = 3'd1;
    localparam logic [2:0] ST_WAIT_OK  = 3'd2;
    localparam logic [2:0] ST_READY    = 3'd3;
    localparam logic [2:0] ST_FAILED   = 3'd4;

    (* ASYNC_REG = "TRUE" *) logic [2:0] clock_ok_sync;
    (* ASYNC_REG = "TRUE" *) logic [2:0] mem_ok_sync;
    logic clock_ok_s;
    logic mem_ok_s;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [STB_W-1:0] stable_cnt;
    logic [RTY_W-1:0] retry_nxt;
    logic             restart;
    logic             fail_evt;
    logic             entering;

    always_ff @(posedge clock) begin
        if (reset) begin
            clock_ok_sync <= '0;
            mem_ok_sync   <= '0;
        end else begin
            clock_ok_sync <= {clock_ok_sync[1:0], clock_ok};
            mem_ok_sync   <= {mem_ok_sync[1:0], mem_ok};
        end
    end

    assign clock_ok_s = clock_ok_sync[2];
    assign mem_ok_s   = mem_ok_sync[2];

    always_comb begin
        state_nxt = state;
        retry_nxt = retry_count;
        restart   = 1'b0;
        fail_evt  = 1'b0;
        if (!clock_ok_s && state != ST_FAILED) begin
            state_nxt = ST_WAIT_CLK;
        end else if (force_retry) begin
            state_nxt = ST_RESET;
            retry_nxt = '0;
            restart   = 1'b1;
        end else begin
            case (state)
                ST_WAIT_CLK: state_nxt = ST_RESET;
                ST_RESET: begin
                    if (cnt == RESET_LAST) state_nxt = ST_WAIT_OK;
                end
                // Reaching stability on the timeout cycle still counts as success.
                ST_WAIT_OK: begin
                    if (mem_ok_s && stable_cnt == STABLE_LAST) state_nxt = ST_READY;
                    else if (cnt == TIMEOUT_LAST)               fail_evt  = 1'b1;
                end
                ST_READY: begin
                    if (!mem_ok_s) fail_evt = 1'b1;
                end
                ST_FAILED: state_nxt = ST_FAILED;
                default:   state_nxt = ST_WAIT_CLK;
            endcase
            if (fail_evt) begin
                if (retry_count == RETRY_MAX) begin
                    state_nxt = ST_FAILED;
                end else begin
                    state_nxt = ST_RESET;
                    retry_nxt = retry_count + RTY_W'(1);
                end
            end
        end
        // A force_retry inside RESET is a fresh entry, so the pulse restarts.
        entering = restart || (state_nxt != state);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_WAIT_CLK;
            cnt           <= '0;
            stable_cnt    <= '0;
            retry_count   <= '0;
            mem_reset_req <= 1'b1;
            mem_ready     <= 1'b0;
            mem_failed    <= 1'b0;
        end else begin
            state       <= state_nxt;
            retry_count <= retry_nxt;

            if (entering) cnt <= '0;
            else if (state == ST_RESET || state == ST_WAIT_OK) cnt <= cnt + CNT_W'(1);

            if (entering || state != ST_WAIT_OK || !mem_ok_s) stable_cnt <= '0;
            else if (stable_cnt != STABLE_MAX) stable_cnt <= stable_cnt + STB_W'(1);

            mem_reset_req <= (state_nxt == ST_WAIT_CLK) || (state_nxt == ST_RESET) ||
                             (state_nxt == ST_FAILED);
            mem_ready     <= (state_nxt == ST_READY);
            mem_failed    <= (state_nxt == ST_FAILED);
        end
    end
endmodule

// File: tb/tb_mem_init_watchdog.sv
// Testbench for mem_init_watchdog: vector table, directed corner sequences, and a random
// phase checked every cycle against a phase/elapsed-time reference model.
module tb_mem_init_watchdog;
    localparam int RC = 8;
    localparam int TC = 100;
    localparam int SC = 4;
    localparam int MR = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       clock_ok = 1'b1;
    logic       mem_ok = 1'b0;
    logic       force_retry = 1'b0;
    logic       mem_reset_req;
    logic       mem_ready;
    logic       mem_failed;
    logic [1:0] retry_count;

    always #5 clock = ~clock;

    mem_init_watchdog #(
        .RESET_CYCLES  (RC),
        .TIMEOUT_CYCLES(TC),
        .STABLE_CYCLES (SC),
        .MAX_RETRIES   (MR)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .clock_ok     (clock_ok),
        .mem_ok       (mem_ok),
        .force_retry  (force_retry),
        .mem_reset_req(mem_reset_req),
        .mem_ready    (mem_ready),
        .mem_failed   (mem_failed),
        .retry_count  (retry_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endtask

    // Reference model: which phase we are in, how long we have been there,
    // and how long mem_ok has been seen high without a break.
    typedef enum {M_WAITCLK, M_RESET, M_WAITOK, M_READY, M_FAILED} mphase_t;
    mphase_t m_phase = M_WAITCLK;
    int      m_age = 0;
    int      m_run = 0;
    int      m_retries = 0;
    logic [2:0] co_line = '0;
    logic [2:0] mo_line = '0;

    task automatic m_enter(input mphase_t p);
        m_phase = p;
        m_age   = 0;
        m_run   = 0;
    endtask

    task automatic m_fail();
        if (m_retries == MR) m_enter(M_FAILED);
        else begin
            m_retries++;
            m_enter(M_RESET);
        end
    endtask

    task automatic model_edge();
        logic cs, ms;
        if (reset) begin
            m_enter(M_WAITCLK);
            m_retries = 0;
            co_line = '0;
            mo_line = '0;
        end else begin
            cs = co_line[2];
            ms = mo_line[2];
            co_line = {co_line[1:0], clock_ok};
            mo_line = {mo_line[1:0], mem_ok};
            if (!cs && m_phase != M_FAILED) begin
                if (m_phase != M_WAITCLK) m_enter(M_WAITCLK);
            end else if (force_retry) begin
                m_enter(M_RESET);
                m_retries = 0;
            end else begin
                case (m_phase)
                    M_WAITCLK: m_enter(M_RESET);
                    M_RESET: begin
                        m_age++;
                        if (m_age == RC) m_enter(M_WAITOK);
                    end
                    M_WAITOK: begin
                        m_age++;
                        m_run = ms ? m_run + 1 : 0;
                        if (m_run == SC) m_enter(M_READY);
                        else if (m_age == TC) m_fail();
                    end
                    M_READY: if (!ms) m_fail();
                    default: ;
                endcase
            end
        end
    endtask

    function automatic int model_word();
        int req;
        req = (m_phase == M_WAITCLK || m_phase == M_RESET || m_phase == M_FAILED) ? 1 : 0;
        return 16 * int'(m_phase == M_FAILED) + 8 * int'(m_phase == M_READY) + 4 * req + m_retries;
    endfunction

    function automatic int dut_word();
        return 16 * int'(mem_failed) + 8 * int'(mem_ready) + 4 * int'(mem_reset_req) +
               int'(retry_count);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
        model_edge();
        check("model_vs_dut(failed,ready,req,retry)", dut_word(), model_word());
    endtask

    task automatic wait_req(input logic target, input int limit, output int n);
        n = 0;
        while (mem_reset_req !== target && n < limit) begin
            step();
            n++;
        end
        if (mem_reset_req !== target) n = -1;
    endtask

    typedef struct {
        logic rst, co, mo, fr;
        int   n;
        logic req, rdy, fld;
        int   rty;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int n;
        int held;
        int seen_ready;

        // Nominal bring-up, loss in READY, and reset from READY.
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0,  2, 1'b1, 1'b0, 1'b0, 0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 11, 1'b1, 1'b0, 1'b0, 0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 20, 1'b0, 1'b0, 1'b0, 0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0,  6, 1'b0, 1'b0, 1'b0, 0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0,  1, 1'b0, 1'b1, 1'b0, 0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0,  1, 1'b0, 1'b1, 1'b0, 0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0,  2, 1'b0, 1'b1, 1'b0, 0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0,  1, 1'b1, 1'b0, 1'b0, 1};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 11, 1'b0, 1'b0, 1'b0, 1};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0,  1, 1'b0, 1'b1, 1'b0, 1};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0,  1, 1'b1, 1'b0, 1'b0, 0};

        for (int i = 0; i < 12; i++) begin
            reset       = vecs[i].rst;
            clock_ok    = vecs[i].co;
            mem_ok      = vecs[i].mo;
            force_retry = vecs[i].fr;
            repeat (vecs[i].n) step();
            check($sformatf("vec%0d", i), dut_word(),
                  16 * int'(vecs[i].fld) + 8 * int'(vecs[i].rdy) + 4 * int'(vecs[i].req) +
                  vecs[i].rty);
        end

        // Glitchy mem_ok: 3 high / 1 low never satisfies the stability window.
        reset  = 1'b0;
        mem_ok = 1'b0;
        wait_req(1'b0, 40, n);
        check("glitch_bringup_cycles", n, 4 + RC);
        seen_ready = 0;
        n = 0;
        while (mem_reset_req == 1'b0 && n < TC + 20) begin
            mem_ok = ((n % 4) != 3);
            step();
            n++;
            if (mem_ready) seen_ready = 1;
        end
        check("glitch_timeout_cycles", n, TC);
        check("glitch_never_ready", seen_ready, 0);
        check("glitch_retry_count", int'(retry_count), 1);
        mem_ok = 1'b0;

        // PLL loss part-way through the reset pulse that follows the timeout.
        repeat (2) step();
        clock_ok = 1'b0;
        held = 1;
        repeat (10) begin
            step();
            if (!mem_reset_req) held = 0;
        end
        check("clkloss_req_held", held, 1);
        check("clkloss_retry_count", int'(retry_count), 1);
        clock_ok = 1'b1;
        wait_req(1'b0, 40, n);
        check("clkloss_fresh_pulse_cycles", n, 4 + RC);
        check("clkloss_retry_after", int'(retry_count), 1);

        // Timeouts until retries are exhausted.
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_req(1'b0, 40, n);
        check("exh_first_pulse_cycles", n, 4 + RC);
        for (int a = 1; a <= MR; a++) begin
            wait_req(1'b1, TC + 10, n);
            check($sformatf("exh_timeout%0d_cycles", a), n, TC);
            check($sformatf("exh_retry%0d", a), int'(retry_count), a);
            wait_req(1'b0, RC + 10, n);
            check($sformatf("exh_pulse%0d_cycles", a), n, RC);
        end
        wait_req(1'b1, TC + 10, n);
        check("exh_last_timeout_cycles", n, TC);
        check("exh_failed", int'(mem_failed), 1);
        check("exh_retry_final", int'(retry_count), MR);
        clock_ok = 1'b0;
        held = 1;
        repeat (20) begin
            step();
            if (!mem_failed || !mem_reset_req) held = 0;
        end
        check("failed_sticky_through_clkloss", held, 1);
        clock_ok = 1'b1;
        repeat (5) step();
        check("failed_still_set", int'(mem_failed), 1);

        // force_retry out of FAILED.
        force_retry = 1'b1;
        step();
        force_retry = 1'b0;
        check("fr_failed_cleared", int'(mem_failed), 0);
        check("fr_retry_cleared", int'(retry_count), 0);
        check("fr_req_high", int'(mem_reset_req), 1);
        wait_req(1'b0, RC + 10, n);
        check("fr_pulse_cycles", n, RC);

        // Random traffic against the reference model.
        for (int i = 0; i < 4000; i++) begin
            reset       = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 149) == 0) clock_ok = ~clock_ok;
            if ($urandom_range(0, 19) == 0)  mem_ok   = ~mem_ok;
            force_retry = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end
endmodule

// File: doc/mem_init_watchdog.md
# mem_init_watchdog

Supervises DDR memory bring-up from the system clock domain and drives the reset request into the memory reset controller's `sys_reset` input. It holds memory in reset until the main PLL is stable, then releases it and waits for the controller's `mem_ok` status. On a calibration timeout or a later loss of `mem_ok`, it re-issues the reset, up to a bounded number of retries. If every retry fails, it latches a failure flag for the boot/status logic.

## Interface
- `RESET_CYCLES`, 64: cycles `mem_reset_req` is held high per reset attempt; must be ≥2.
- `TIMEOUT_CYCLES`, 16777216: cycles allowed in WAIT_OK before an attempt fails; must be > `STABLE_CYCLES`.
- `STABLE_CYCLES`, 256: consecutive synchronized `mem_ok` high cycles required to declare ready; must be ≥1.
- `MAX_RETRIES`, 3: re-attempts after the first attempt before entering FAILED.
- `clock` input 1: system clock; the only clock.
- `reset` input 1: synchronous, active-high reset.
- `clock_ok` input 1: main PLL locked; asynchronous, synchronized internally.
- `mem_ok` input 1: memory controller ready; from the ui_clk domain, synchronized internally.
- `force_retry` input 1: single-cycle pulse from software; restarts bring-up and clears the retry count.
- `mem_reset_req` output 1: active-high reset request to the memory reset controller.
- `mem_ready` output 1: memory is up and stable.
- `mem_failed` output 1: all retries exhausted; sticky.
- `retry_count` output $clog2(MAX_RETRIES+1): number of retries consumed.

## Operation
- Synchronizers
  - `clock_ok` and `mem_ok` each pass through a 3-flop ASYNC_REG chain, reset to 0.
  - The FSM sees only the synchronized versions, `clock_ok_s` and `mem_ok_s`.
- Counters
  - `cnt`: width $clog2(TIMEOUT_CYCLES); zeroed on every state entry.
  - `stable_cnt`: width $clog2(STABLE_CYCLES+1); zeroed whenever `mem_ok_s`=0 and on WAIT_OK entry; saturates.
- States and outputs
  - WAIT_CLK: `mem_reset_req`=1. Goes to RESET when `clock_ok_s`=1.
  - RESET: `mem_reset_req`=1, `cnt` increments. Goes to WAIT_OK at `cnt`==RESET_CYCLES-1.
  - WAIT_OK: `mem_reset_req`=0, `cnt` increments, `stable_cnt` counts.
    - Goes to READY when `stable_cnt` reaches STABLE_CYCLES.
    - Otherwise at `cnt`==TIMEOUT_CYCLES-1 a FAIL event occurs.
  - READY: `mem_ready`=1, `mem_reset_req`=0. `mem_ok_s`=0 causes a FAIL event.
  - FAILED: `mem_reset_req`=1, `mem_failed`=1. Left only via `reset` or `force_retry`.
- FAIL event
  - If `retry_count`==MAX_RETRIES: go to FAILED.
  - Else: `retry_count`+1 and go to RESET.
- Priority, highest first:
  1. `reset`.
  2. `clock_ok_s`=0 in any state except FAILED: go to WAIT_CLK. `retry_count` is not incremented.
  3. `force_retry`: go to RESET, `retry_count`←0, `mem_failed`←0.
  4. Normal transitions.
- Simultaneous events
  - If a WAIT_OK timeout coincides with the cycle `stable_cnt` reaches STABLE_CYCLES, READY wins.
  - `force_retry` while in RESET restarts `cnt` from 0.
- Reset values
  - State WAIT_CLK, both counters 0, `retry_count`=0.
  - `mem_reset_req`=1, `mem_ready`=0, `mem_failed`=0.
  - Synchronizer flops 0.

## Timing
- All outputs are registered and decoded from the next-state value, so they change on the same edge the state changes.
- Input to FSM latency: 3 cycles through the synchronizers.
- `mem_reset_req` high duration per attempt: exactly RESET_CYCLES cycles; WAIT_CLK and FAILED time is in addition.
- READY asserts `STABLE_CYCLES`+3 cycles after `mem_ok` rises in WAIT_OK, assuming no other event intervenes.
- `mem_ok` drop in READY: `mem_ready` falls and `mem_reset_req` rises 4 cycles after the `mem_ok` edge (3 synchronizer cycles plus the registered transition).
- WAIT_OK timeout fires exactly TIMEOUT_CYCLES cycles after WAIT_OK entry.
- No combinational path from any input to any output.

## Test plan
All scenarios use RESET_CYCLES=8, TIMEOUT_CYCLES=100, STABLE_CYCLES=4, MAX_RETRIES=2.
- Nominal bring-up
  - Stimulus: `reset` released, `clock_ok`=1 at cycle 0; `mem_ok` rises 20 cycles after `mem_reset_req` falls.
  - Required: `mem_reset_req` high for exactly 8 cycles after WAIT_CLK exit; `mem_ready`=1 at 7 cycles after the `mem_ok` rise; `retry_count`=0.
- Timeout and exhaustion
  - Stimulus: `mem_ok` held 0.
  - Required: three reset pulses of 8 cycles each, with 100-cycle WAIT_OK gaps; `retry_count` steps 0→1→2; then `mem_failed`=1 and `mem_reset_req`=1, both held.
- Glitchy `mem_ok`
  - Stimulus: in WAIT_OK, `mem_ok` toggles 3 cycles high, 1 cycle low, repeatedly.
  - Required: READY is never reached; timeout occurs; `retry_count`=1.
- Loss in READY
  - Stimulus: drop `mem_ok` for 1 cycle while in READY.
  - Required: `mem_ready`=0 and `mem_reset_req`=1 at edge +4; `retry_count`=1; `mem_ready` returns after re-calibration.
- Clock loss mid-reset
  - Stimulus: drop `clock_ok` during RESET at `cnt`=5, then restore it.
  - Required: WAIT_CLK is entered; `retry_count` unchanged; a fresh full 8-cycle reset pulse follows restoration.
- `force_retry` from FAILED
  - Stimulus: pulse `force_retry` while in FAILED.
  - Required: `mem_failed`=0 and `retry_count`=0 on the next edge; an 8-cycle reset pulse follows.
  - Also check: `reset` asserted in READY returns every output to its reset value on the next edge.
